// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter state encoding, parity constants and default widths
package uart_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PRESCALE_W = 6;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-source request bundle (P_DATA/Data_Valid/PAR_EN/PAR_TYP/Prescale in, TX_OUT/Busy out)
interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  TX_OUT;
  logic                  Busy;
  modport master (output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale, input TX_OUT, Busy);
  modport slave  (input P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale, output TX_OUT, Busy);
endinterface

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: bit-period counter; ports clk/rst_n, en_i (frame active), clr_i (accept), data_en_i (in DATA), eff_ps_i -> bit_done_o, bit_idx_o
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W,
  parameter int IW         = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic                  data_en_i,
  input  logic [PRESCALE_W-1:0] eff_ps_i,
  output logic                  bit_done_o,
  output logic [IW-1:0]         bit_idx_o
);
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  always_comb begin
    bit_done_o = en_i && (cnt_q == eff_ps_i - PRESCALE_W'(1));
    cnt_d      = (clr_i || !en_i || bit_done_o) ? '0 : cnt_q + PRESCALE_W'(1);
    idx_d      = clr_i ? '0 : (bit_done_o && data_en_i) ? idx_q + IW'(1) : idx_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end
  assign bit_idx_o = idx_q;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter; CLK/RST (async active-low) plus slave bundle tx (byte request in, registered TX_OUT/Busy out)
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input logic      CLK,
  input logic      RST,
  uart_tx_if.slave tx
);
  localparam int IW = $clog2(DATA_WIDTH);
  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [PRESCALE_W-1:0] eff_ps_q, eff_ps_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  accept, bit_done, last_bit;
  logic [IW-1:0]         bit_idx;
  assign accept   = tx.Data_Valid && (state_q == IDLE);
  assign last_bit = bit_idx == IW'(DATA_WIDTH - 1);
  uart_tx_bit_timer #(
    .DATA_WIDTH(DATA_WIDTH),
    .PRESCALE_W(PRESCALE_W),
    .IW        (IW)
  ) u_timer (
    .clk       (CLK),
    .rst_n     (RST),
    .en_i      (state_q != IDLE),
    .clr_i     (accept),
    .data_en_i (state_q == DATA),
    .eff_ps_i  (eff_ps_q),
    .bit_done_o(bit_done),
    .bit_idx_o (bit_idx)
  );
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    eff_ps_d  = eff_ps_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d   = START;
        shreg_d   = tx.P_DATA;
        par_en_d  = tx.PAR_EN;
        par_bit_d = (tx.PAR_TYP == PAR_ODD) ? ~^tx.P_DATA : ^tx.P_DATA;
        eff_ps_d  = (tx.Prescale == '0) ? PRESCALE_W'(1) : tx.Prescale;
      end
      START:  if (bit_done) state_d = DATA;
      DATA: if (bit_done) begin
        shreg_d = shreg_q >> 1;
        if (last_bit) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: if (bit_done) state_d = STOP;
      STOP:   if (bit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are computed from the next state so the registered line changes on the same edge as the state.
    tx_d   = (state_d == START)  ? 1'b0 :
             (state_d == DATA)   ? shreg_d[0] :
             (state_d == PARITY) ? par_bit_d : 1'b1;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      eff_ps_q  <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      eff_ps_q  <= eff_ps_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end
  assign tx.TX_OUT = tx_q;
  assign tx.Busy   = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx
module tb_uart_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  uart_tx_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) u_if ();
  uart_tx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK(clk),
    .RST(rst_n),
    .tx (u_if)
  );
  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
    @(negedge clk);
    u_if.P_DATA     = d;
    u_if.PAR_EN     = pe;
    u_if.PAR_TYP    = pt;
    u_if.Prescale   = ps;
    u_if.Data_Valid = 1'b1;
    @(negedge clk);
    u_if.Data_Valid = 1'b0;
  endtask
  task automatic check_frame(input logic [7:0] d, input logic pe, input logic par, input int ps,
                             input int mode, input string nm);
    logic [10:0] bits;
    logic bad_tx, bad_busy, got_tx, got_busy;
    int n;
    n = pe ? 11 : 10;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (pe) bits[9] = par;
    for (int i = 0; i < n; i++) begin
      bad_tx = 1'b0;
      bad_busy = 1'b0;
      got_tx = bits[i];
      got_busy = 1'b1;
      for (int c = 0; c < ps; c++) begin
        if (mode == 1) begin
          u_if.Data_Valid = 1'b1;
          u_if.P_DATA = 8'hFF;
        end
        if (mode == 2 && i == 3 && c == 0) begin
          u_if.Prescale = 6'd4;
          u_if.PAR_EN = 1'b1;
          u_if.PAR_TYP = 1'b1;
          u_if.P_DATA = 8'h00;
        end
        if (u_if.TX_OUT !== bits[i]) begin bad_tx = 1'b1; got_tx = u_if.TX_OUT; end
        if (u_if.Busy !== 1'b1) begin bad_busy = 1'b1; got_busy = u_if.Busy; end
        @(negedge clk);
      end
      checks++;
      if (bad_tx) begin
        failures++;
        $display("FAIL %s bit%0d tx got=%b exp=%b", nm, i, got_tx, bits[i]);
      end
      checks++;
      if (bad_busy) begin
        failures++;
        $display("FAIL %s bit%0d busy got=%b exp=1", nm, i, got_busy);
      end
    end
    u_if.Data_Valid = 1'b0;
    checks++;
    if (u_if.Busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_end got=%b exp=0", nm, u_if.Busy);
    end
    checks++;
    if (u_if.TX_OUT !== 1'b1) begin
      failures++;
      $display("FAIL %s tx_end got=%b exp=1", nm, u_if.TX_OUT);
    end
  endtask
  task automatic check_idle(input int cycles, input string nm);
    logic bad;
    bad = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      if (u_if.TX_OUT !== 1'b1 || u_if.Busy !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL %s idle tx/busy got=%b%b exp=10", nm, u_if.TX_OUT, u_if.Busy);
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (u_if.TX_OUT !== 1'b1 || u_if.Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_held tx/busy got=%b%b exp=10", u_if.TX_OUT, u_if.Busy);
    end
    rst_n = 1'b1;
    check_idle(3, "reset_release");
    send(8'hA5, 1'b0, 1'b0, 6'd8);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (u_if.TX_OUT !== 1'b1 || u_if.Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_frame tx/busy got=%b%b exp=10", u_if.TX_OUT, u_if.Busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_idle(20, "reset_abandon");
  endtask
  task automatic test_basic();
    send(8'hA5, 1'b0, 1'b0, 6'd8);
    check_frame(8'hA5, 1'b0, 1'b0, 8, 0, "a5_ps8");
  endtask
  task automatic test_parity();
    send(8'h07, 1'b1, 1'b0, 6'd16);
    check_frame(8'h07, 1'b1, 1'b1, 16, 0, "07_even");
    send(8'h07, 1'b1, 1'b1, 6'd16);
    check_frame(8'h07, 1'b1, 1'b0, 16, 0, "07_odd");
  endtask
  task automatic test_ignore_busy();
    send(8'h3C, 1'b0, 1'b0, 6'd4);
    check_frame(8'h3C, 1'b0, 1'b0, 4, 1, "3c_ignore");
    check_idle(20, "ignore_after");
  endtask
  task automatic test_cfg_change();
    send(8'h96, 1'b0, 1'b0, 6'd8);
    check_frame(8'h96, 1'b0, 1'b0, 8, 2, "96_cfg_change");
    send(8'h96, 1'b1, 1'b0, 6'd4);
    check_frame(8'h96, 1'b1, 1'b0, 4, 0, "96_ps4_par");
  endtask
  task automatic test_min_prescale();
    send(8'h55, 1'b0, 1'b0, 6'd0);
    check_frame(8'h55, 1'b0, 1'b0, 1, 0, "55_ps0");
    send(8'h55, 1'b0, 1'b0, 6'd1);
    check_frame(8'h55, 1'b0, 1'b0, 1, 0, "55_ps1");
  endtask
  initial begin
    u_if.P_DATA = '0;
    u_if.Data_Valid = 1'b0;
    u_if.PAR_EN = 1'b0;
    u_if.PAR_TYP = 1'b0;
    u_if.Prescale = '0;
    test_reset();
    test_basic();
    test_parity();
    test_ignore_busy();
    test_cfg_change();
    test_min_prescale();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
